pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the RV32I 5-stage pipeline.
- Drives stall/flush into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and drives the PC write enable.
- Resolves load-use hazards, taken-branch/jump redirects, instruction-fetch not-ready, and multi-cycle data-memory waits.
- Includes a timeout watchdog on data-memory waits.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a redirect (1..7); covers fetch latency after redirect.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before timeout (1..65535).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- id_rs1  in  5  rs1 index of instruction in ID.
- id_rs2  in  5  rs2 index of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- imem_ready  in  1  instruction fetch data valid this cycle.
- mem_req  in  1  MEM stage is performing a data access.
- mem_ready  in  1  data memory completes access this cycle.
- pc_we  out  1  PC update enable.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_stall  out  1  hold ID/EX.
- id_ex_flush  out  1  load bubble into ID/EX.
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_flush  out  1  load bubble into MEM/WB.
- mem_timeout  out  1  sticky timeout flag.
- state_o  out  2  current FSM state, for debug.
- stall_cycles  out  32  performance counter (see Optional Feature).
- flush_events  out  32  performance counter (see Optional Feature).

Behaviour:
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is unused and recovers to RUN.
- Registered state: flush_cnt (3 b), wait_cnt (16 b), ret_state, ret_cnt.
- Outputs are combinational from current state and inputs. Same-cycle response, zero latency.
- Reset (reset=0, async):
  - state=RUN, counters=0, mem_timeout=0.
  - While asserted: pc_we=0, if_id_flush=1, id_ex_flush=1; all other outputs 0.
- Priority, highest first: memory freeze > redirect > load-use > fetch not-ready.
- Memory freeze condition: mem_req & !mem_ready, evaluated in any state.
  - Outputs: pc_we=0, if_id_stall=1, id_ex_stall=1, ex_mem_stall=1, mem_wb_flush=1; all flush except mem_wb_flush are 0.
  - ex_redirect is ignored while frozen; the EX instruction is held and re-presents the redirect after the freeze.
  - Next state = MEM_WAIT. Save ret_state (RUN or FLUSH) and the remaining flush_cnt.
- MEM_WAIT:
  - wait_cnt increments each frozen cycle.
  - On mem_ready=1: return to ret_state with the saved count; wait_cnt cleared; outputs this cycle are normal RUN/FLUSH decode.
  - If wait_cnt reaches MEM_TIMEOUT: set mem_timeout (sticky until reset), clear wait_cnt, continue waiting. The freeze is not abandoned.
- Redirect (ex_redirect=1, not frozen):
  - Outputs: pc_we=1, if_id_flush=1, id_ex_flush=1.
  - If FLUSH_CYCLES>1: next state=FLUSH, flush_cnt=FLUSH_CYCLES-1.
- FLUSH:
  - Outputs: if_id_flush=1, pc_we=imem_ready.
  - flush_cnt decrements each non-frozen cycle; at flush_cnt==1 the next state is RUN.
  - A new redirect in FLUSH reloads flush_cnt=FLUSH_CYCLES-1 and flushes ID/EX again.
- Load-use condition (RUN only): ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Outputs: pc_we=0, if_id_stall=1, id_ex_flush=1.
  - Single bubble. No state change; the hazard clears as the load advances.
- Fetch not-ready (RUN, !imem_ready, no higher event): pc_we=0, if_id_flush=1.
- If if_id_stall and if_id_flush would both be 1, flush wins: stall forced 0.
- Default RUN, no events: pc_we=1, all stall/flush outputs 0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments every cycle in which pc_we=0 while reset is deasserted.
  - flush_events increments on each accepted redirect.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 32'h0 and no counter flops synthesised.

Test Plan:
- Reset then release; imem_ready=1, no events -> during reset pc_we=0, if_id_flush=1, id_ex_flush=1; after release pc_we=1, state_o=0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_we=0, if_id_stall=1, id_ex_flush=1. Repeat with ex_rd=0 -> no stall.
- FLUSH_CYCLES=3, ex_redirect pulse -> if_id_flush=1 for exactly 3 cycles, id_ex_flush=1 for the first cycle only, state returns to 0.
- mem_req=1, mem_ready=0 for 4 cycles with ex_redirect=1 -> 4 frozen cycles, state_o=2. Then mem_ready=1 -> redirect processed the following cycle.
- MEM_TIMEOUT=8, mem_ready held 0 for 10 cycles -> mem_timeout rises after the 8th wait cycle and stays 1 after mem_ready; cleared only by reset.
- PIPE_CTRL_PERF_EN defined, 2 redirects plus 4-cycle freeze -> flush_events=2, stall_cycles=4. Macro undefined -> both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the RV32I 5-stage pipeline: load-use, redirect, fetch and data-memory hazards.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        imem_ready,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_flush,
    output logic        mem_timeout,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0]  RELOAD    = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state, ret_state, eff_state, next_state;
    logic [2:0]  flush_cnt, ret_cnt, eff_cnt, next_cnt;
    logic [15:0] wait_cnt;
    logic        frozen, load_use, stall_raw;

    assign frozen   = mem_req & ~mem_ready;
    assign load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign state_o  = state;

    // MEM_WAIT decodes as whatever state the freeze interrupted
    always_comb begin
        case (state)
            RUN:      begin eff_state = RUN;       eff_cnt = flush_cnt; end
            FLUSH:    begin eff_state = FLUSH;     eff_cnt = flush_cnt; end
            MEM_WAIT: begin eff_state = ret_state; eff_cnt = ret_cnt;   end
            default:  begin eff_state = RUN;       eff_cnt = 3'd0;      end
        endcase
    end

    always_comb begin
        pc_we        = 1'b0;
        stall_raw    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        next_state   = eff_state;
        next_cnt     = eff_cnt;
        if (!reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (frozen) begin
            stall_raw    = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            next_state   = MEM_WAIT;
        end else if (ex_redirect) begin
            pc_we       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = FLUSH;
                next_cnt   = RELOAD;
            end else begin
                next_state = RUN;
                next_cnt   = 3'd0;
            end
        end else if (eff_state == FLUSH) begin
            pc_we       = imem_ready;
            if_id_flush = 1'b1;
            if (eff_cnt <= 3'd1) begin
                next_state = RUN;
                next_cnt   = 3'd0;
            end else begin
                next_cnt   = eff_cnt - 3'd1;
            end
        end else if (load_use) begin
            stall_raw   = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            if_id_flush = 1'b1;
        end else begin
            pc_we = 1'b1;
        end
    end

    assign if_id_stall = stall_raw & ~if_id_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            flush_cnt   <= 3'd0;
            ret_state   <= RUN;
            ret_cnt     <= 3'd0;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_cnt;
            if (frozen) begin
                if (state != MEM_WAIT) begin
                    ret_state <= eff_state;
                    ret_cnt   <= eff_cnt;
                end
                // timeout only flags the stall; the freeze continues until mem_ready
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt    <= 16'd0;
                    mem_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end else begin
                wait_cnt <= 16'd0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic redirect_taken;
    assign redirect_taken = ex_redirect & ~frozen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (!pc_we)         stall_cycles <= stall_cycles + 32'd1;
            if (redirect_taken) flush_events <= flush_events + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'h0;
    assign flush_events = 32'h0;
`endif

endmodule
